spi_mcp4922_dac: RTL and testbench
==================================

// Module: spi_mcp4922_dac
// PURPOSE
//  SPI master driving an MCP4922 12-bit DAC; output-side counterpart of the MCP3202 ADC capture path.
//  Accepts 12-bit samples over a valid/ready handshake, serialises a 16-bit write command (mode 0, MSB first),
//  then pulses LDAC so the analog output updates. Runs directly on the 135 MHz system clock.
// PARAMETERS
//  SCK_HALF    8   clk cycles per SCK half-period (8 -> 135/16 = 8.44 MHz, below the 20 MHz part max)
//  CS_SETUP    8   cycles CS low before the first SCK rise (59 ns; tCSSR >= 40 ns)
//  CS_HOLD     8   cycles after the last SCK fall before CS rises
//  CS_GAP      8   minimum CS-high cycles between frames
//  LDAC_WIDTH  14  LDAC low pulse width in cycles (104 ns; tLD >= 100 ns)
//  BUF         0   command bit 14: Vref input buffer
//  GA_N        1   command bit 13: 1 = 1x gain, 0 = 2x gain
// PORTS
//  clk         in   1   135 MHz system clock
//  reset       in   1   synchronous, active-high reset
//  EN          in   1   core enable; low aborts any frame in progress
//  i_DATA      in   12  channel A sample
//  i_DATA_B    in   12  channel B sample (present only with DAC_STEREO_EN)
//  i_VALID     in   1   sample(s) valid
//  o_READY     out  1   core accepts a sample this cycle
//  MOSI        out  1   DAC SDI
//  SCK         out  1   SPI clock, idles low
//  CS          out  1   chip select, active low
//  LDAC        out  1   latch DAC, active low
//  BUSY        out  1   high from acceptance until end of GAP
// BEHAVIOUR
//  Reset: CS=1, SCK=0, MOSI=0, LDAC=1, o_READY=0, BUSY=0, state=IDLE, all counters 0.
//  States: IDLE -> SETUP -> SHIFT -> HOLD -> (next channel: GAP_CH -> SETUP) -> LATCH -> GAP -> IDLE.
//  IDLE: o_READY = EN (registered). Accept on i_VALID && o_READY: latch data, o_READY low next cycle.
//  Command word {CH, BUF, GA_N, 1'b1 (SHDN_N), D[11:0]}; CH=0 for channel A, 1 for B.
//  SETUP: CS falls the cycle after acceptance; MOSI = bit 15 in that same cycle; hold CS_SETUP cycles.
//  SHIFT: 16 bits; each bit = SCK_HALF cycles low then SCK_HALF cycles high; MOSI changes only at SCK fall
//    (or SETUP entry for bit 15), so it is stable across every rising edge.
//  HOLD: after the 16th high phase SCK returns low, MOSI=0, CS stays low CS_HOLD cycles, then CS rises.
//  LATCH: LDAC low exactly LDAC_WIDTH cycles, starting the cycle after CS rises; CS stays high.
//  GAP: CS high >= CS_GAP cycles after LDAC rises; then IDLE, o_READY reasserts if EN.
//  Frame timing, defaults: CS low = 8 + 16*16 + 8 = 272 cycles; accept-to-next-o_READY = 272+14+8+2 = 296.
//  i_VALID while BUSY is ignored (no queueing); upstream holds data until o_READY.
//  EN low in any non-IDLE state: next cycle CS=1, SCK=0, MOSI=0, LDAC=1, no LDAC pulse for that frame,
//    enter GAP (full CS_GAP enforced), then IDLE with o_READY low until EN returns.
//  EN low in LATCH: LDAC returns high immediately (pulse truncated); treat the DAC output as undefined.
//  reset mid-frame: same output values as reset, next cycle.
//  Bit and cycle counters saturate/wrap only at their terminal counts; no free-running sample timer.
// CONFIGURATION
//  DAC_STEREO_EN defined: i_DATA_B exists; one handshake accepts both channels; frames A then B
//    separated by CS_GAP cycles CS high (GAP_CH), single LDAC pulse after frame B updates both outputs.
//  DAC_STEREO_EN undefined: i_DATA_B absent; channel A only (CH=0); one frame, then LDAC.
// TESTING
//  Reset held 4 cycles -> CS=1, SCK=0, LDAC=1, o_READY=0; reset released, EN=1 -> o_READY=1 next cycle.
//  i_DATA=12'hA5C accepted -> MOSI at 16 SCK rises = 16'h3A5C; CS low exactly 272 cycles; 16 SCK pulses.
//  After CS rise -> LDAC low exactly 14 cycles; o_READY back 296 cycles after acceptance.
//  i_VALID pulsed while BUSY with 12'h123 -> ignored; next frame carries only the data offered at o_READY.
//  EN dropped after 5th SCK rise -> CS=1, SCK=0 next cycle; no LDAC pulse; o_READY stays low until EN=1.
//  DAC_STEREO_EN, A=12'h800, B=12'h0FF -> words 16'h3800 then 16'hB0FF, >=8 cycle CS gap, one LDAC pulse.

Source files
------------

// File: rtl/spi_mcp4922_dac.sv
`timescale 1ns/1ps
// spi_mcp4922_dac
//   SPI master for an MCP4922 12-bit DAC. It takes a sample over a valid/ready
//   handshake and shifts out the 16-bit write command {CH, BUF, GA_N, SHDN_N=1, D}
//   in SPI mode 0, MSB first. It then pulses LDAC low so the analog output updates.
//   Build option: define DAC_STEREO_EN to add i_DATA_B. One handshake then sends
//   frame A, a CS-high gap, and frame B, and a single LDAC pulse updates both outputs.
// Ports
//   clk, reset    system clock, synchronous active-high reset
//   EN            core enable; low aborts a frame in progress
//   i_DATA        channel A sample      i_DATA_B  channel B sample (stereo only)
//   i_VALID       sample valid          o_READY   core accepts this cycle
//   MOSI/SCK/CS   SPI to DAC (SCK idles low, CS active low)
//   LDAC          DAC latch, active low
//   BUSY          high from acceptance until the end of the post-frame gap
module spi_mcp4922_dac #(
    parameter int SCK_HALF   = 8,
    parameter int CS_SETUP   = 8,
    parameter int CS_HOLD    = 8,
    parameter int CS_GAP     = 8,
    parameter int LDAC_WIDTH = 14,
    parameter bit BUF        = 1'b0,
    parameter bit GA_N       = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EN,
    input  logic [11:0] i_DATA,
`ifdef DAC_STEREO_EN
    input  logic [11:0] i_DATA_B,
`endif
    input  logic        i_VALID,
    output logic        o_READY,
    output logic        MOSI,
    output logic        SCK,
    output logic        CS,
    output logic        LDAC,
    output logic        BUSY
);
    localparam int CW = 16;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP_CH, LATCH, GAP} state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [3:0]     bit_cnt;
    logic [14:0]    shreg;      // bits still to send after the one on MOSI
    logic [15:0]    cmd_a;

    assign cmd_a = {1'b0, BUF, GA_N, 1'b1, i_DATA};

`ifdef DAC_STEREO_EN
    logic           ch;
    logic [11:0]    data_b;
    logic [15:0]    cmd_b;
    assign cmd_b = {1'b1, BUF, GA_N, 1'b1, data_b};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            o_READY <= 1'b0;
            MOSI    <= 1'b0;
            SCK     <= 1'b0;
            CS      <= 1'b1;
            LDAC    <= 1'b1;
            BUSY    <= 1'b0;
`ifdef DAC_STEREO_EN
            ch      <= 1'b0;
            data_b  <= '0;
`endif
        end else if (!EN && state != IDLE && state != GAP) begin
            // Abort: park the bus, skip LDAC, still enforce a full gap.
            state   <= GAP;
            cnt     <= '0;
            bit_cnt <= '0;
            MOSI    <= 1'b0;
            SCK     <= 1'b0;
            CS      <= 1'b1;
            LDAC    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    o_READY <= EN;
                    if (i_VALID && o_READY) begin
                        o_READY <= 1'b0;
                        BUSY    <= 1'b1;
                        state   <= SETUP;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        CS      <= 1'b0;
                        MOSI    <= cmd_a[15];
                        shreg   <= cmd_a[14:0];
`ifdef DAC_STEREO_EN
                        ch      <= 1'b0;
                        data_b  <= i_DATA_B;
`endif
                    end
                end
                SETUP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(CS_SETUP - 1)) begin
                        state <= SHIFT;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(SCK_HALF - 1))
                        SCK <= 1'b1;
                    // MOSI only moves on the falling edge, so it is stable at every rise.
                    if (cnt == CW'(2 * SCK_HALF - 1)) begin
                        SCK <= 1'b0;
                        cnt <= '0;
                        if (bit_cnt == 4'd15) begin
                            state <= HOLD;
                            MOSI  <= 1'b0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            MOSI    <= shreg[14];
                            shreg   <= {shreg[13:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(CS_HOLD - 1)) begin
                        CS    <= 1'b1;
                        cnt   <= '0;
                        state <= LATCH;
`ifdef DAC_STEREO_EN
                        if (!ch)
                            state <= GAP_CH;
`endif
                    end
                end
`ifdef DAC_STEREO_EN
                GAP_CH: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(CS_GAP - 1)) begin
                        state   <= SETUP;
                        cnt     <= '0;
                        bit_cnt <= '0;
                        ch      <= 1'b1;
                        CS      <= 1'b0;
                        MOSI    <= cmd_b[15];
                        shreg   <= cmd_b[14:0];
                    end
                end
`endif
                LATCH: begin
                    // First cycle after CS rise keeps LDAC high; the pulse follows.
                    cnt <= cnt + 1'b1;
                    if (cnt == '0)
                        LDAC <= 1'b0;
                    if (cnt == CW'(LDAC_WIDTH)) begin
                        LDAC  <= 1'b1;
                        state <= GAP;
                        cnt   <= '0;
                    end
                end
                GAP: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(CS_GAP - 1)) begin
                        state <= IDLE;
                        cnt   <= '0;
                        BUSY  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_mcp4922_dac.sv
`timescale 1ns/1ps
module tb_spi_mcp4922_dac;
    localparam int SCK_HALF = 8, CS_SETUP = 8, CS_HOLD = 8, CS_GAP = 8, LDAC_WIDTH = 14;
    localparam bit BUF = 1'b0, GA_N = 1'b1;
    localparam int FRAME_CS = CS_SETUP + 16 * 2 * SCK_HALF + CS_HOLD;
`ifdef DAC_STEREO_EN
    localparam int NW = 2;
`else
    localparam int NW = 1;
`endif
    // acceptance to o_READY: CS-low frames, channel gap, 1 cycle to LDAC, pulse, gap, 1 to IDLE
    localparam int LAT = NW * FRAME_CS + (NW - 1) * CS_GAP + 1 + LDAC_WIDTH + CS_GAP + 1;

    logic clk = 1'b0, reset = 1'b1, EN = 1'b0, i_VALID = 1'b0;
    logic [11:0] i_DATA = '0;
`ifdef DAC_STEREO_EN
    logic [11:0] i_DATA_B = '0;
`endif
    logic o_READY, MOSI, SCK, CS, LDAC, BUSY;

    spi_mcp4922_dac dut (
        .clk(clk), .reset(reset), .EN(EN), .i_DATA(i_DATA),
`ifdef DAC_STEREO_EN
        .i_DATA_B(i_DATA_B),
`endif
        .i_VALID(i_VALID), .o_READY(o_READY), .MOSI(MOSI), .SCK(SCK),
        .CS(CS), .LDAC(LDAC), .BUSY(BUSY)
    );

    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0, n_fail = 0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: reconstructs each CS frame and LDAC pulse from the pins.
    logic [15:0] word = '0;
    int cs_len = 0, rises = 0, ldac_len = 0, cs_hi = 0, ldac_falls = 0, cs_rise_cyc = 0;
    logic [15:0] word_q[$];
    int len_q[$], rise_q[$], ldac_q[$], dly_q[$], gap_q[$];
    logic p_cs = 1'b1, p_sck = 1'b0, p_ldac = 1'b1;

    always @(negedge clk) begin
        if (!CS) begin
            cs_len++;
            if (SCK && !p_sck) begin word = {word[14:0], MOSI}; rises++; end
        end
        if (CS && !p_cs) begin
            word_q.push_back(word); len_q.push_back(cs_len); rise_q.push_back(rises);
            cs_rise_cyc = cyc; cs_len = 0; rises = 0; word = '0; cs_hi = 1;
        end else if (CS) cs_hi++;
        if (!CS && p_cs) gap_q.push_back(cs_hi);
        if (!LDAC) ldac_len++;
        if (!LDAC && p_ldac) begin ldac_falls++; dly_q.push_back(cyc - cs_rise_cyc); end
        if (LDAC && !p_ldac) begin ldac_q.push_back(ldac_len); ldac_len = 0; end
        p_cs = CS; p_sck = SCK; p_ldac = LDAC;
    end

    task automatic clear_q;
        word_q.delete(); len_q.delete(); rise_q.delete();
        ldac_q.delete(); dly_q.delete(); gap_q.delete();
    endtask

    task automatic tick;
        @(negedge clk); #1;
    endtask

    task automatic accept(input logic [11:0] a, input logic [11:0] b, output int c0);
        int k = 0;
        while (!o_READY && k < 2000) begin tick(); k++; end
        chk("ready_before_accept", o_READY, 1'b1);
        i_DATA = a;
`ifdef DAC_STEREO_EN
        i_DATA_B = b;
`else
        if (b != 12'h0) i_DATA = a;
`endif
        i_VALID = 1'b1;
        @(posedge clk); #1;
        c0 = cyc;
        i_VALID = 1'b0;
    endtask

    task automatic check_frame(input logic [11:0] a, input logic [11:0] b, input int c0);
        int c1, k;
        logic [15:0] exp_w[2];
        k = 0;
        while (!o_READY && k < 3000) begin tick(); k++; end
        c1 = cyc;
        chk("ready_latency", c1 - c0, LAT);
        chk("busy_after_frame", BUSY, 1'b0);
        exp_w[0] = {1'b0, BUF, GA_N, 1'b1, a};
        exp_w[1] = {1'b1, BUF, GA_N, 1'b1, b};
        chk("frame_count", word_q.size(), NW);
        for (int i = 0; i < NW && word_q.size() > 0; i++) begin
            chk("mosi_word", word_q.pop_front(), exp_w[i]);
            chk("cs_low_cycles", len_q.pop_front(), FRAME_CS);
            chk("sck_pulses", rise_q.pop_front(), 16);
        end
        chk("ldac_pulse_count", ldac_q.size(), 1);
        if (ldac_q.size() > 0) begin
            chk("ldac_width", ldac_q.pop_front(), LDAC_WIDTH);
            chk("ldac_after_cs", dly_q.pop_front(), 1);
        end
`ifdef DAC_STEREO_EN
        chk("channel_gap_ok", (gap_q.size() >= 2) && (gap_q[gap_q.size()-1] >= CS_GAP), 1'b1);
`endif
        clear_q();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, k, f;
        logic [11:0] a, b;

        // Reset state
        repeat (4) @(posedge clk);
        tick();
        chk("rst_cs", CS, 1'b1);
        chk("rst_sck", SCK, 1'b0);
        chk("rst_mosi", MOSI, 1'b0);
        chk("rst_ldac", LDAC, 1'b1);
        chk("rst_ready", o_READY, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        reset = 1'b0; EN = 1'b1;
        tick();
        chk("ready_after_rst", o_READY, 1'b1);

        // Directed words
        clear_q();
        accept(12'hA5C, 12'h0FF, c0);
        chk("busy_on_accept", BUSY, 1'b1);
        chk("ready_drop", o_READY, 1'b0);
        check_frame(12'hA5C, 12'h0FF, c0);
        accept(12'h800, 12'h0FF, c0);
        check_frame(12'h800, 12'h0FF, c0);

        // Random samples, including the code extremes
        for (int i = 0; i < 6; i++) begin
            a = (i == 0) ? 12'hFFF : (i == 1) ? 12'h000 : 12'($urandom);
            b = 12'($urandom);
            accept(a, b, c0);
            check_frame(a, b, c0);
        end

        // i_VALID while busy must be ignored
        a = 12'($urandom); b = 12'($urandom);
        accept(a, b, c0);
        repeat (40) tick();
        i_DATA = 12'h123; i_VALID = 1'b1;
        repeat (5) tick();
        i_VALID = 1'b0;
        check_frame(a, b, c0);
        accept(12'h789, 12'h456, c0);
        check_frame(12'h789, 12'h456, c0);

        // EN dropped after the 5th SCK rise
        f = ldac_falls;
        accept(12'($urandom), 12'($urandom), c0);
        k = 0;
        while (rises < 5 && k < 500) begin tick(); k++; end
        chk("abort_point", rises, 5);
        EN = 1'b0;
        tick();
        chk("abort_cs", CS, 1'b1);
        chk("abort_sck", SCK, 1'b0);
        chk("abort_mosi", MOSI, 1'b0);
        chk("abort_ldac", LDAC, 1'b1);
        repeat (30) tick();
        chk("abort_ready_low", o_READY, 1'b0);
        chk("abort_busy_done", BUSY, 1'b0);
        chk("abort_no_ldac", ldac_falls, f);
        EN = 1'b1;
        tick();
        chk("abort_ready_back", o_READY, 1'b1);
        clear_q();

        // Reset in mid-frame
        accept(12'($urandom), 12'($urandom), c0);
        repeat (100) tick();
        reset = 1'b1;
        tick();
        chk("midrst_cs", CS, 1'b1);
        chk("midrst_sck", SCK, 1'b0);
        chk("midrst_mosi", MOSI, 1'b0);
        chk("midrst_ldac", LDAC, 1'b1);
        chk("midrst_ready", o_READY, 1'b0);
        chk("midrst_busy", BUSY, 1'b0);
        reset = 1'b0;
        tick();
        chk("midrst_ready_back", o_READY, 1'b1);
        clear_q();

        // Recovery frame
        a = 12'($urandom); b = 12'($urandom);
        accept(a, b, c0);
        check_frame(a, b, c0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
